// File: rtl/if_id_stage.sv
// if_id_stage: 2-entry IF/ID skid buffer with MIPS field split; IFID_STALL_CNT_EN adds a saturating stall_cnt output
module if_id_stage #(
  parameter int INSTR_W = 32,
  parameter int PC_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
`ifdef IFID_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic [15:0]        imm16
);
  logic [INSTR_W-1:0] instr_q [2];
  logic [PC_W-1:0] pc_q [2];
  logic head, tail, push, pop;
  logic [1:0] count;
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready;
  // pointers and occupancy; flush empties the buffer and drops any same-cycle push
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      head <= 1'b0;
      tail <= 1'b0;
    end else if (flush) begin
      count <= '0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      head <= head ^ pop;
      tail <= tail ^ push;
    end
  // entry storage needs no reset since count gates its visibility
  always_ff @(posedge clk)
    if (push) begin
      instr_q[tail] <= in_instr;
      pc_q[tail] <= in_pc;
    end
  // head entry drives decode; NOP and zero pc4 whenever the buffer is empty
  always_comb begin
    out_instr = out_valid ? instr_q[head] : NOP_INSTR;
    out_pc4 = out_valid ? pc_q[head] + PC_W'(4) : '0;
    opcode = out_instr[31:26];
    rs = out_instr[25:21];
    rt = out_instr[20:16];
    rd = out_instr[15:11];
    shamt = out_instr[10:6];
    funct = out_instr[5:0];
    imm16 = out_instr[15:0];
  end
`ifdef IFID_STALL_CNT_EN
  // cycles where decode holds off a valid head; saturates and survives flush
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized and directed checks of if_id_stage against a queue model
module tb_if_id_stage;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid;
  logic [31:0] out_instr, out_pc4;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int tests = 0, fails = 0;
  logic [63:0] q[$];
  int stall = 0;

  if_id_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc4(out_pc4), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct),
`ifdef IFID_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .imm16(imm16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    logic [31:0] ei, ep;
    ei = q.size() > 0 ? q[0][63:32] : 32'h0;
    ep = q.size() > 0 ? q[0][31:0] + 32'd4 : 32'h0;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_instr", 64'(out_instr), 64'(ei));
    chk("out_pc4", 64'(out_pc4), 64'(ep));
    chk("opcode", 64'(opcode), 64'(ei[31:26]));
    chk("rs", 64'(rs), 64'(ei[25:21]));
    chk("rt", 64'(rt), 64'(ei[20:16]));
    chk("rd", 64'(rd), 64'(ei[15:11]));
    chk("shamt", 64'(shamt), 64'(ei[10:6]));
    chk("funct", 64'(funct), 64'(ei[5:0]));
    chk("imm16", 64'(imm16), 64'(ei[15:0]));
`ifdef IFID_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stall));
`endif
  endtask

  task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
    logic do_push, do_pop;
    in_valid = v; in_instr = i; in_pc = p; out_ready = r; flush = f;
    @(negedge clk);
    model_check();
    do_push = v && q.size() < 2 && !f;
    do_pop = q.size() > 0 && r;
    if (q.size() > 0 && !r && stall < 16'hFFFF) stall++;
    @(posedge clk);
    #1;
    if (f) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({i, p});
    end
  endtask

  task automatic mid_reset();
    in_valid = 0; flush = 0;
    #2 rst = 1;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst imm16", 64'(imm16), 64'd0);
    chk("rst out_pc4", 64'(out_pc4), 64'd0);
    q.delete();
    stall = 0;
    #3 rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1;
    #1;
    chk("init out_valid", 64'(out_valid), 64'd0);
    chk("init in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1;
    cycle(1, 32'h2008_000F, 32'h100, 1, 0);
    in_valid = 0;
    #2;
    chk("pt out_valid", 64'(out_valid), 64'd1);
    chk("pt opcode", 64'(opcode), 64'h08);
    chk("pt rs", 64'(rs), 64'h0);
    chk("pt rt", 64'(rt), 64'h8);
    chk("pt imm16", 64'(imm16), 64'h000F);
    chk("pt out_pc4", 64'(out_pc4), 64'h104);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h2008_7AFF, 32'h200, 0, 0);
    cycle(1, 32'h2008_8AFF, 32'h204, 0, 0);
    #2;
    chk("fill in_ready", 64'(in_ready), 64'd0);
    chk("fill imm16", 64'(imm16), 64'h7AFF);
    cycle(1, 32'h2008_9AFF, 32'h208, 0, 0);
    cycle(1, 32'h2008_9AFF, 32'h208, 1, 0);
    #2;
    chk("drain imm16 b", 64'(imm16), 64'h8AFF);
    cycle(1, 32'h2008_9AFF, 32'h208, 1, 0);
    in_valid = 0;
    #2;
    chk("drain imm16 c", 64'(imm16), 64'h9AFF);
    cycle(0, 0, 0, 1, 0);
    #2;
    chk("drain empty", 64'(out_valid), 64'd0);
    cycle(1, 32'h1111_1111, 32'h300, 0, 0);
    cycle(1, 32'h2222_2222, 32'h304, 0, 0);
    cycle(1, 32'h3333_3333, 32'h308, 0, 1);
    in_valid = 0;
    #2;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'hABCD_1234, 32'hFFFF_FFFC, 0, 0);
    #2;
    chk("wrap out_pc4", 64'(out_pc4), 64'd0);
    chk("wrap out_valid", 64'(out_valid), 64'd1);
    cycle(0, 0, 0, 1, 0);
    mid_reset();
    cycle(1, 32'h0123_4567, 32'h400, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
`ifdef IFID_STALL_CNT_EN
    #2;
    chk("stall5", 64'(stall_cnt), 64'd5);
`endif
    cycle(0, 0, 0, 1, 1);
`ifdef IFID_STALL_CNT_EN
    #2;
    chk("stall after flush", 64'(stall_cnt), 64'd5);
`endif
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(60) == 0) mid_reset();
      cycle($urandom_range(9) < 7, $urandom, $urandom_range(3) == 0 ? 32'hFFFF_FFFC : $urandom,
            $urandom_range(9) < 6, $urandom_range(15) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
